// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared constants and types for the TDM FIR scheduler
package fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_NUM_CH = 2;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;

    typedef enum logic {
        COLLECT = 1'b0,
        ISSUE   = 1'b1
    } state_t;

endpackage

// File: rtl/fir_chan_hold.sv
// rtl/fir_chan_hold.sv - single-channel sample holding register with full/ready
module fir_chan_hold #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [DATA_W-1:0] sample,
    input  logic              take,
    output logic              ready,
    output logic              full,
    output logic [DATA_W-1:0] hold
);

    assign ready = ~full;

    // Capture and take are exclusive: take only happens while full, capture only while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            hold <= '0;
        end else if (valid && !full) begin
            hold <= sample;
            full <= 1'b1;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fir_tdm_scheduler.sv
// rtl/fir_tdm_scheduler.sv - shares one FIR core between channels by strict-order TDM
module fir_tdm_scheduler
    import fir_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int CH_W     = 1,
    parameter int MAX_INFL = 15
) (
    input  logic                     aclk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ready,
    output logic                     s_axis_data_tvalid,
    output logic [DATA_W-1:0]        s_axis_data_tdata,
    input  logic                     s_axis_data_tready,
    input  logic                     m_axis_data_tvalid,
    input  logic [DATA_W-1:0]        m_axis_data_tdata,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic [15:0]              frames,
    output logic                     err
);

    localparam int INFL_W = $clog2(MAX_INFL + 1);
    localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [INFL_W-1:0] INFL_MAX = INFL_W'(MAX_INFL);

    state_t              state;
    logic [CH_W-1:0]     idx;
    logic [CH_W-1:0]     next_idx;
    logic [CH_W-1:0]     optr;
    logic [INFL_W-1:0]   inflight;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   take;
    logic [DATA_W-1:0]   hold [NUM_CH];
    logic                accept;

    assign accept   = s_axis_data_tvalid & s_axis_data_tready;
    assign next_idx = idx + 1'b1;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_hold
        assign take[i] = accept && (idx == CH_W'(i));

        fir_chan_hold #(.DATA_W(DATA_W)) u_hold (
            .clk    (aclk),
            .reset  (reset),
            .valid  (ch_valid[i]),
            .sample (ch_data[i*DATA_W +: DATA_W]),
            .take   (take[i]),
            .ready  (ch_ready[i]),
            .full   (full[i]),
            .hold   (hold[i])
        );
    end

    // A frame starts only once every channel holds a sample, so the core always sees 0..NUM_CH-1.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state              <= COLLECT;
            idx                <= '0;
            s_axis_data_tvalid <= 1'b0;
            s_axis_data_tdata  <= '0;
            frames             <= '0;
        end else begin
            case (state)
                COLLECT: begin
                    if (&full) begin
                        state              <= ISSUE;
                        idx                <= '0;
                        s_axis_data_tvalid <= 1'b1;
                        s_axis_data_tdata  <= hold[0];
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (idx == LAST_CH) begin
                            state              <= COLLECT;
                            idx                <= '0;
                            s_axis_data_tvalid <= 1'b0;
                            frames             <= frames + 16'd1;
                        end else begin
                            idx               <= next_idx;
                            s_axis_data_tdata <= hold[next_idx];
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            optr      <= '0;
        end else begin
            out_valid <= m_axis_data_tvalid;
            if (m_axis_data_tvalid) begin
                out_data <= m_axis_data_tdata;
                out_ch   <= optr;
                optr     <= (optr == LAST_CH) ? '0 : optr + 1'b1;
            end
        end
    end

    // In-flight count saturates at both ends; either saturation is flagged as a sticky error.
    always_ff @(posedge aclk) begin
        if (reset) begin
            inflight <= '0;
            err      <= 1'b0;
        end else if (accept && !m_axis_data_tvalid) begin
            if (inflight == INFL_MAX) begin
                err <= 1'b1;
            end else begin
                inflight <= inflight + 1'b1;
            end
        end else if (m_axis_data_tvalid && !accept) begin
            if (inflight == '0) begin
                err <= 1'b1;
            end else begin
                inflight <= inflight - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// tb/tb_fir_tdm_scheduler.sv - scoreboard bench for the TDM FIR scheduler
module tb_fir_tdm_scheduler;

    localparam int NUM_CH = 2;
    localparam int DATA_W = 16;
    localparam int CH_W   = 1;

    logic                     aclk = 1'b0;
    logic                     reset = 1'b1;
    logic [NUM_CH-1:0]        ch_valid = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic [NUM_CH-1:0]        ch_ready;
    logic                     s_axis_data_tvalid;
    logic [DATA_W-1:0]        s_axis_data_tdata;
    logic                     s_axis_data_tready = 1'b0;
    logic                     m_axis_data_tvalid = 1'b0;
    logic [DATA_W-1:0]        m_axis_data_tdata = '0;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic [15:0]              frames;
    logic                     err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0]      sq[$];
    logic [CH_W+DATA_W-1:0] oq[$];

    always #5 aclk = ~aclk;

    fir_tdm_scheduler #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W), .MAX_INFL(15)
    ) dut (
        .aclk               (aclk),
        .reset              (reset),
        .ch_valid           (ch_valid),
        .ch_data            (ch_data),
        .ch_ready           (ch_ready),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .s_axis_data_tready (s_axis_data_tready),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .out_valid          (out_valid),
        .out_data           (out_data),
        .out_ch             (out_ch),
        .frames             (frames),
        .err                (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic stray(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected beat with empty scoreboard at %0t", name, $time);
    endtask

    // Monitor: every accepted issue beat and every tagged output is checked against the queues.
    initial begin
        logic [DATA_W-1:0]      e_s;
        logic [CH_W+DATA_W-1:0] e_o;
        forever begin
            @(negedge aclk);
            if (!reset) begin
                if (s_axis_data_tvalid && s_axis_data_tready) begin
                    if (sq.size() == 0) stray("issue_beat");
                    else begin
                        e_s = sq.pop_front();
                        check("issue_tdata", 32'(s_axis_data_tdata), 32'(e_s));
                    end
                end
                if (out_valid) begin
                    if (oq.size() == 0) stray("out_beat");
                    else begin
                        e_o = oq.pop_front();
                        check("out_data", 32'(out_data), 32'(e_o[DATA_W-1:0]));
                        check("out_ch", 32'(out_ch), 32'(e_o[CH_W+DATA_W-1:DATA_W]));
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        ch_valid = '0;
        m_axis_data_tvalid = 1'b0;
        s_axis_data_tready = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        #1 reset = 1'b0;
    endtask

    task automatic drive_frame(input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        ch_data  = {d1, d0};
        ch_valid = 2'b11;
        @(posedge aclk);
        #1 ch_valid = '0;
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (frames == 16'(n)) break;
        end
        check("frames", 32'(frames), 32'(n));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20; i++) begin
            if (sq.size() == 0 && oq.size() == 0) break;
            @(negedge aclk);
        end
        check({name, "_sq_left"}, 32'(sq.size()), 32'd0);
        check({name, "_oq_left"}, 32'(oq.size()), 32'd0);
    endtask

    initial begin
        // Test 1: reset state, simultaneous capture, back-to-back issue
        do_reset();
        @(negedge aclk);
        check("rst_ch_ready", 32'(ch_ready), 32'h3);
        check("rst_tvalid", 32'(s_axis_data_tvalid), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_frames", 32'(frames), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        s_axis_data_tready = 1'b1;
        sq.push_back(16'h0100);
        sq.push_back(16'hFF00);
        drive_frame(16'h0100, 16'hFF00);
        wait_frames(1);
        drain("t1");

        // Test 2: ch1 early, ch0 late; issue waits for ch0 and keeps channel order
        do_reset();
        s_axis_data_tready = 1'b1;
        ch_data  = {16'h7FFF, 16'h0000};
        ch_valid = 2'b10;
        @(posedge aclk);
        #1 ch_valid = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            check("t2_wait_tvalid", 32'(s_axis_data_tvalid), 32'h0);
        end
        check("t2_ch_ready", 32'(ch_ready), 32'h1);
        sq.push_back(16'h8000);
        sq.push_back(16'h7FFF);
        ch_data  = {16'h0000, 16'h8000};
        ch_valid = 2'b01;
        @(posedge aclk);
        #1 ch_valid = '0;
        @(negedge aclk);
        check("t2_lat_e", 32'(s_axis_data_tvalid), 32'h0);
        @(negedge aclk);
        check("t2_lat_e1", 32'(s_axis_data_tvalid), 32'h1);
        wait_frames(1);
        drain("t2");

        // Test 3: backpressure on the ch0 beat
        do_reset();
        sq.push_back(16'h1234);
        sq.push_back(16'h5678);
        drive_frame(16'h1234, 16'h5678);
        @(negedge aclk);
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("t3_hold_tvalid", 32'(s_axis_data_tvalid), 32'h1);
            check("t3_hold_tdata", 32'(s_axis_data_tdata), 32'h1234);
        end
        check("t3_frames_stalled", 32'(frames), 32'h0);
        @(posedge aclk);
        #1 s_axis_data_tready = 1'b1;
        wait_frames(1);
        drain("t3");

        // Test 4: two frames out, four beats back with channel tags; in-flight returns to 0
        do_reset();
        s_axis_data_tready = 1'b1;
        sq.push_back(16'h0011);
        sq.push_back(16'h0022);
        drive_frame(16'h0011, 16'h0022);
        wait_frames(1);
        sq.push_back(16'h0033);
        sq.push_back(16'h0044);
        drive_frame(16'h0033, 16'h0044);
        wait_frames(2);
        @(posedge aclk);
        #1;
        for (int k = 0; k < 4; k++) begin
            oq.push_back({1'(k % 2), 16'(k + 1)});
            m_axis_data_tvalid = 1'b1;
            m_axis_data_tdata  = 16'(k + 1);
            @(posedge aclk);
            #1;
        end
        m_axis_data_tvalid = 1'b0;
        drain("t4");
        check("t4_err_clean", 32'(err), 32'h0);
        oq.push_back({1'b0, 16'h0005});
        m_axis_data_tvalid = 1'b1;
        m_axis_data_tdata  = 16'h0005;
        @(posedge aclk);
        #1 m_axis_data_tvalid = 1'b0;
        @(negedge aclk);
        check("t4_inflight_zero_err", 32'(err), 32'h1);
        drain("t4b");

        // Test 5: output beat with nothing issued
        do_reset();
        oq.push_back({1'b0, 16'h0BAD});
        m_axis_data_tvalid = 1'b1;
        m_axis_data_tdata  = 16'h0BAD;
        @(posedge aclk);
        #1 m_axis_data_tvalid = 1'b0;
        @(negedge aclk);
        check("t5_err_set", 32'(err), 32'h1);
        repeat (3) @(negedge aclk);
        check("t5_err_sticky", 32'(err), 32'h1);
        drain("t5");

        // Test 6: reset after ch0 issued, then a fresh frame from ch0
        do_reset();
        s_axis_data_tready = 1'b1;
        sq.push_back(16'h0AAA);
        drive_frame(16'h0AAA, 16'h0BBB);
        @(posedge aclk);
        @(posedge aclk);
        #1;
        reset = 1'b1;
        s_axis_data_tready = 1'b0;
        @(posedge aclk);
        #1 reset = 1'b0;
        @(negedge aclk);
        check("t6_ch_ready", 32'(ch_ready), 32'h3);
        check("t6_tvalid", 32'(s_axis_data_tvalid), 32'h0);
        check("t6_frames", 32'(frames), 32'h0);
        check("t6_err", 32'(err), 32'h0);
        check("t6_sq_popped", 32'(sq.size()), 32'h0);
        s_axis_data_tready = 1'b1;
        sq.push_back(16'h0C0C);
        sq.push_back(16'h0D0D);
        drive_frame(16'h0C0C, 16'h0D0D);
        wait_frames(1);
        drain("t6");

        // Test 7: 16 issues with no returns overflows the 15-deep in-flight count
        do_reset();
        s_axis_data_tready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            sq.push_back(16'(2 * f));
            sq.push_back(16'(2 * f + 1));
            drive_frame(16'(2 * f), 16'(2 * f + 1));
            wait_frames(f + 1);
            if (f == 6) check("t7_err_at_14", 32'(err), 32'h0);
        end
        @(negedge aclk);
        check("t7_err_overflow", 32'(err), 32'h1);
        drain("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_tdm_scheduler.md
Name: fir_tdm_scheduler

Overview:
- Shares one AXI-Stream FIR filter core between NUM_CH audio channels by time-division multiplexing.
- Samples are interleaved into the core in strict channel order, which the core's multichannel mode requires.
- Filtered outputs are demultiplexed back to channel tags.
- Sits between the per-channel audio sample sources and the FIR core, and also tracks in-flight samples for error detection.

Parameters:
- NUM_CH, 2, number of channels sharing the FIR core (>=2)
- DATA_W, 16, sample width, signed two's complement
- CH_W, 1, channel index width; must satisfy 2**CH_W >= NUM_CH
- MAX_INFL, 15, maximum samples in flight inside the FIR core; sizes the in-flight counter

Ports:
- aclk  in  1  clock
- reset  in  1  synchronous reset, active-high
- ch_valid  in  NUM_CH  per-channel sample valid
- ch_data  in  NUM_CH*DATA_W  per-channel samples; channel i occupies bits [i*DATA_W +: DATA_W]
- ch_ready  out  NUM_CH  per-channel ready
- s_axis_data_tvalid  out  1  to FIR core input
- s_axis_data_tdata  out  DATA_W  to FIR core input
- s_axis_data_tready  in  1  from FIR core
- m_axis_data_tvalid  in  1  FIR core output beat; no backpressure
- m_axis_data_tdata  in  DATA_W  FIR core output sample
- out_valid  out  1  tagged filtered sample valid, one cycle
- out_data  out  DATA_W  filtered sample
- out_ch  out  CH_W  channel of out_data
- frames  out  16  count of completed issue frames, wraps at 0xFFFF->0
- err  out  1  sticky error: output beat with nothing in flight, or in-flight overflow

Behaviour:
Reset values:
- ch_ready all ones; all other outputs 0.
- Hold flags, in-flight count and issue/output channel pointers all 0.
- State is COLLECT.
- Reset mid-operation discards held samples and in-flight bookkeeping. The FIR core must be reset in the same cycle.

Input side:
- One holding register plus full flag per channel.
- ch_ready[i] = ~full[i], driven combinationally from the registered flag.
- Capture occurs on ch_valid[i] & ch_ready[i]: store the data and set full[i] at that edge.
- Channels capture independently, and simultaneous captures on all channels are legal.

State machine:
- COLLECT -> ISSUE when all full flags are 1, as registered. The issue index resets to 0.
- ISSUE:
  - s_axis_data_tvalid=1 and tdata=hold[idx], both registered and stable until accepted.
  - On tvalid & tready: clear full[idx], increment the in-flight count, idx++.
  - Acceptance of idx==NUM_CH-1 increments frames and returns to COLLECT; tvalid drops the next cycle.
  - A channel may refill as soon as its own flag clears, but the next frame starts only when every channel is full again. Order is always 0..NUM_CH-1.
- Latency: the last channel captured at edge E gives s_axis_data_tvalid=1 after edge E+1.
- Back-to-back acceptance gives one beat per cycle, so a frame takes NUM_CH cycles with tready held high.

Output side:
- On m_axis_data_tvalid, at the next edge:
  - out_valid=1, out_data=tdata, out_ch=output pointer.
  - The output pointer increments and wraps NUM_CH-1 -> 0.
  - The in-flight count decrements.
- A simultaneous issue and output beat leaves in-flight unchanged.
- An output beat with in-flight==0 sets err and does not decrement (saturates at 0). The beat is still forwarded with the pointer advanced.
- An issue with in-flight==MAX_INFL sets err and the count saturates.
- err clears only on reset.

Decomposition:
- Shared package fir_pkg:
  - DATA_W and default NUM_CH constants.
  - Sample typedef (signed [DATA_W-1:0]).
  - State enum {COLLECT, ISSUE}.
- One natural sub-module, fir_chan_hold: a single-channel holding register with full/ready, instantiated NUM_CH times.
- Scheduler FSM, output demux and counters stay in the top module.

Test Plan:
1. Reset, NUM_CH=2. Drive ch0=0x0100 and ch1=0xFF00 valid in the same cycle, tready=1. Required: tdata 0x0100 then 0xFF00 on consecutive cycles, and frames=1.
2. ch1 arrives 5 cycles before ch0, with ch1=0x7FFF and ch0=0x8000. Required: no issue until ch0 is captured; issue order is still 0x8000 then 0x7FFF.
3. tready low for 3 cycles during the ch0 beat. Required: tvalid held and tdata stable at the ch0 value; ch1 is not issued until ch0 is accepted.
4. FIR returns 4 beats (0x0001, 0x0002, 0x0003, 0x0004) after 2 frames. Required: out_ch sequence 0,1,0,1 and in-flight returns to 0; err=0.
5. m_axis_data_tvalid pulsed with no prior issue. Required: err=1 and stays set; out_valid still pulses with out_ch=0.
6. Reset asserted mid-frame after ch0 has been issued. Required: next cycle ch_ready=11, tvalid=0, frames=0, err=0. The next frame starts again at ch0.
